fetch_stage: RTL and testbench

- IF stage of the OTTER pipeline; sits directly upstream of the memory stage's instruction port.
- Owns the PC and drives the instruction-port address/read strobe.
- Pairs each returned instruction with its PC in an IF/ID register.
- Handles hazard-unit stall and branch/jump redirect; a skid register preserves the unbuffered instruction word across stalls.

---
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - OTTER IF stage: PC, IF/ID register, stall skid hold, redirect; optional MISALIGN_TRAP_EN
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] MEM_ADDR_1,
  output logic        MEM_READ_1,
  input  logic [31:0] D_OUT_1,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  output logic [31:0] IF_IR,
  output logic        IF_VALID,
  output logic        IF_MISALIGN
);

  logic [31:0] pc;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        hold_vld;
  logic [31:0] hold_ir;
  logic [31:0] redirect_target;

  // Instructions are word aligned; low target bits never reach the PC.
  assign redirect_target = REDIRECT_PC & 32'hFFFF_FFFC;

  // PC, IF/ID register and the skid word that survives a stall.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc       <= RESET_PC;
      if_pc    <= 32'h0000_0000;
      if_valid <= 1'b0;
      hold_vld <= 1'b0;
      hold_ir  <= 32'h0000_0000;
    end else if (REDIRECT) begin
      // The word fetched from the old PC returns next cycle and is killed.
      pc       <= redirect_target;
      if_pc    <= pc;
      if_valid <= 1'b0;
      hold_vld <= 1'b0;
    end else if (STALL) begin
      // Memory is unbuffered: capture the word on the first stall edge only.
      if (!hold_vld) begin
        hold_ir  <= D_OUT_1;
        hold_vld <= 1'b1;
      end
    end else begin
      if_pc    <= pc;
      pc       <= pc + 32'd4;
      if_valid <= 1'b1;
      hold_vld <= 1'b0;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;

  // Flag a misaligned redirect target alongside the bubble/first target instruction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      misalign <= 1'b0;
    end else if (REDIRECT) begin
      misalign <= (REDIRECT_PC[1:0] != 2'b00);
    end else if (!STALL) begin
      misalign <= 1'b0;
    end
  end

  assign IF_MISALIGN = misalign;
`else
  assign IF_MISALIGN = 1'b0;
`endif

  assign MEM_ADDR_1 = pc;
  assign MEM_READ_1 = RST_N;
  assign IF_PC      = if_pc;
  assign IF_PC4     = if_pc + 32'd4;
  assign IF_VALID   = if_valid;

  // Held word takes precedence over the live memory output while a stall is in effect.
  always_comb begin
    IF_IR = D_OUT_1;
    if (!if_valid) begin
      IF_IR = NOP_INSTR;
    end else if (hold_vld) begin
      IF_IR = hold_ir;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef MISALIGN_TRAP_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  logic        CLK;
  logic        RST_N;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] MEM_ADDR_1;
  logic        MEM_READ_1;
  logic [31:0] D_OUT_1;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC4;
  logic [31:0] IF_IR;
  logic        IF_VALID;
  logic        IF_MISALIGN;

  int n_cmp;
  int n_fail;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .MEM_ADDR_1(MEM_ADDR_1), .MEM_READ_1(MEM_READ_1),
    .D_OUT_1(D_OUT_1), .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_IR(IF_IR),
    .IF_VALID(IF_VALID), .IF_MISALIGN(IF_MISALIGN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] m(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Synchronous instruction memory: word valid the cycle after its address.
  always @(posedge CLK) D_OUT_1 <= m(MEM_ADDR_1);

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_ir;
    logic        e_mis;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic [31:0] ea, input logic cp, input logic [31:0] ep,
                              input logic ev, input logic [31:0] ei, input logic em);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rpc; v.e_addr = ea; v.chk_pc = cp;
    v.e_pc = ep; v.e_v = ev; v.e_ir = ei; v.e_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    RST_N = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;

    //            stall redir rpc           addr          chk pc            v     ir              mis
    vecs[0]  = mk(0, 0, 32'h0,         32'h100,       0, 32'h0,        0, NOP,            0);
    vecs[1]  = mk(0, 0, 32'h0,         32'h104,       1, 32'h100,      1, m(32'h100),     0);
    vecs[2]  = mk(1, 0, 32'h0,         32'h108,       1, 32'h104,      1, m(32'h104),     0);
    vecs[3]  = mk(1, 0, 32'h0,         32'h108,       1, 32'h104,      1, m(32'h104),     0);
    vecs[4]  = mk(1, 0, 32'h0,         32'h108,       1, 32'h104,      1, m(32'h104),     0);
    vecs[5]  = mk(0, 0, 32'h0,         32'h108,       1, 32'h104,      1, m(32'h104),     0);
    vecs[6]  = mk(0, 0, 32'h0,         32'h10C,       1, 32'h108,      1, m(32'h108),     0);
    vecs[7]  = mk(0, 1, 32'h200,       32'h110,       1, 32'h10C,      1, m(32'h10C),     0);
    vecs[8]  = mk(0, 0, 32'h0,         32'h200,       0, 32'h0,        0, NOP,            0);
    vecs[9]  = mk(1, 0, 32'h0,         32'h204,       1, 32'h200,      1, m(32'h200),     0);
    vecs[10] = mk(1, 1, 32'h300,       32'h204,       1, 32'h200,      1, m(32'h200),     0);
    vecs[11] = mk(0, 0, 32'h0,         32'h300,       0, 32'h0,        0, NOP,            0);
    vecs[12] = mk(0, 1, 32'hFFFF_FFF8, 32'h304,       1, 32'h300,      1, m(32'h300),     0);
    vecs[13] = mk(0, 0, 32'h0,         32'hFFFF_FFF8, 0, 32'h0,        0, NOP,            0);
    vecs[14] = mk(0, 0, 32'h0,         32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 1, m(32'hFFFF_FFF8), 0);
    vecs[15] = mk(0, 0, 32'h0,         32'h0,         1, 32'hFFFF_FFFC, 1, m(32'hFFFF_FFFC), 0);
    vecs[16] = mk(0, 1, 32'h202,       32'h4,         1, 32'h0,        1, m(32'h0),       0);
    vecs[17] = mk(1, 0, 32'h0,         32'h200,       0, 32'h0,        0, NOP,            1);
    vecs[18] = mk(0, 0, 32'h0,         32'h200,       0, 32'h0,        0, NOP,            1);
    vecs[19] = mk(1, 0, 32'h0,         32'h204,       1, 32'h200,      1, m(32'h200),     0);
    vecs[20] = mk(1, 0, 32'h0,         32'h204,       1, 32'h200,      1, m(32'h200),     0);

    // Reset state while RST_N is held low
    #12;
    chk("rst_read", {31'h0, MEM_READ_1}, 32'h0);
    chk("rst_addr", MEM_ADDR_1, RST_PC);
    chk("rst_valid", {31'h0, IF_VALID}, 32'h0);
    chk("rst_ifpc", IF_PC, 32'h0);
    chk("rst_ir", IF_IR, NOP);
    chk("rst_mis", {31'h0, IF_MISALIGN}, 32'h0);

    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 21; i++) begin
      #1;
      chk($sformatf("v%0d_addr", i), MEM_ADDR_1, vecs[i].e_addr);
      chk($sformatf("v%0d_read", i), {31'h0, MEM_READ_1}, 32'h1);
      chk($sformatf("v%0d_valid", i), {31'h0, IF_VALID}, {31'h0, vecs[i].e_v});
      chk($sformatf("v%0d_ir", i), IF_IR, vecs[i].e_ir);
      chk($sformatf("v%0d_mis", i), {31'h0, IF_MISALIGN}, {31'h0, vecs[i].e_mis & MIS_EN});
      if (vecs[i].chk_pc) begin
        chk($sformatf("v%0d_ifpc", i), IF_PC, vecs[i].e_pc);
        chk($sformatf("v%0d_ifpc4", i), IF_PC4, vecs[i].e_pc + 32'd4);
      end
      STALL       = vecs[i].stall;
      REDIRECT    = vecs[i].redir;
      REDIRECT_PC = vecs[i].rpc;
      @(negedge CLK);
    end

    // Asynchronous reset in the middle of a stall, between clock edges
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_read", {31'h0, MEM_READ_1}, 32'h0);
    chk("arst_addr", MEM_ADDR_1, RST_PC);
    chk("arst_valid", {31'h0, IF_VALID}, 32'h0);
    chk("arst_ifpc", IF_PC, 32'h0);
    chk("arst_ir", IF_IR, NOP);
    chk("arst_mis", {31'h0, IF_MISALIGN}, 32'h0);
    STALL = 1'b0;
    REDIRECT = 1'b0;

    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rel0_addr", MEM_ADDR_1, RST_PC);
    chk("rel0_valid", {31'h0, IF_VALID}, 32'h0);
    @(negedge CLK);
    #1;
    chk("rel1_valid", {31'h0, IF_VALID}, 32'h1);
    chk("rel1_ifpc", IF_PC, RST_PC);
    chk("rel1_ir", IF_IR, m(RST_PC));
    chk("rel1_addr", MEM_ADDR_1, RST_PC + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
